// File: rtl/mux_4to1_rr_pkg.sv
// Shared constants, types and pointer helper for the 4-to-1 round-robin mux.
package mux_4to1_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic sel_t next_ptr(sel_t p);
    return p + sel_t'(1);
  endfunction

endpackage

// File: rtl/mux_4to1_rr_if.sv
// Channel bundle for mux_4to1_rr: four valid/ready inputs and one tagged output.
// MUX_4TO1_RR_LOCK_EN adds the in_last/out_last packet-boundary signals.
interface mux_4to1_rr_if
  import mux_4to1_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [DATA_W-1:0]      out_data;
  sel_t                   out_sel;
  logic                   out_valid;
  logic                   out_ready;
`ifdef MUX_4TO1_RR_LOCK_EN
  logic [N_CH-1:0]        in_last;
  logic                   out_last;
`endif

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
`ifdef MUX_4TO1_RR_LOCK_EN
    , input in_last, output out_last
`endif
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
`ifdef MUX_4TO1_RR_LOCK_EN
    , output in_last, input out_last
`endif
  );

endinterface

// File: rtl/mux_4to1_rr_arb4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr wins.
module rr_arb4
  import mux_4to1_pkg::*;
(
  input  logic [N_CH-1:0] req_i,
  input  sel_t            ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output sel_t            gnt_idx_o,
  output logic            gnt_any_o
);

  sel_t idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = ptr_i;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ptr_i + sel_t'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Four valid/ready channels merged round-robin into one registered, source-tagged output.
// MUX_4TO1_RR_LOCK_EN: hold arbitration on a channel until its in_last beat is accepted.
//
// state    | meaning
// ST_EMPTY | output slot holds no beat, out_valid=0
// ST_FULL  | output slot holds a beat waiting for out_ready
module mux_4to1_rr
  import mux_4to1_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic           clk,
  input  logic           rst,
  mux_4to1_rr_if.slave   bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  sel_t              sel_q, sel_d;
  sel_t              ptr_q, ptr_d;

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   gnt;
  sel_t              gnt_idx;
  logic              gnt_any;
  logic              free;
  logic              accept;

`ifdef MUX_4TO1_RR_LOCK_EN
  logic              lock_q, lock_d;
  sel_t              lock_ch_q, lock_ch_d;
  logic              last_q, last_d;
`endif

  // While locked, only the owning channel may compete.
  always_comb begin
    req = bus.in_valid;
`ifdef MUX_4TO1_RR_LOCK_EN
    if (lock_q) req = bus.in_valid & (4'b0001 << lock_ch_q);
`endif
  end

  rr_arb4 u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign free         = (state_q == ST_EMPTY) | bus.out_ready;
  assign accept       = free & gnt_any & ~rst;
  assign bus.in_ready = accept ? gnt : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef MUX_4TO1_RR_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    last_d    = last_q;
`endif
    if (accept) begin
      state_d = ST_FULL;
      data_d  = bus.in_data[int'(gnt_idx)*DATA_W +: DATA_W];
      sel_d   = gnt_idx;
`ifdef MUX_4TO1_RR_LOCK_EN
      last_d = bus.in_last[gnt_idx];
      if (bus.in_last[gnt_idx]) begin
        lock_d = 1'b0;
        ptr_d  = next_ptr(gnt_idx);
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = gnt_idx;
      end
`else
      ptr_d = next_ptr(gnt_idx);
`endif
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef MUX_4TO1_RR_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      last_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef MUX_4TO1_RR_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      last_q    <= last_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
`ifdef MUX_4TO1_RR_LOCK_EN
  assign bus.out_last  = last_q;
`endif

endmodule

// File: doc/mux_4to1_rr.md
Name: mux_4to1_rr

Overview:
- Inverse of the team's 1-to-4 demux: merges four valid/ready input channels onto one registered output channel.
- A round-robin arbiter picks among requesting channels; the winner's beat is captured into a single output register.
- `out_sel` tags each output beat with its source channel, so a downstream demux can route it back out.
- Sits between per-channel producers and a shared downstream consumer.

Parameters:
- DATA_W, 8, width of each channel's data word.

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  4  per-channel valid.
- in_ready  output  4  per-channel ready (combinational).
- out_data  output  DATA_W  registered output data.
- out_sel  output  2  registered source-channel index of out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0, so channel 0 is highest priority.
  - in_ready=0 while rst is high.
- Transfer rules:
  - A transfer occurs on any edge where valid&ready are both high, on either side.
  - Inputs must hold data/valid until accepted; the block never drops a beat.
- Slot state (2-state FSM):
  - EMPTY (out_valid=0) -> FULL on an input accept.
  - FULL & out_ready & no new accept -> EMPTY.
  - FULL & out_ready & new accept -> FULL (back-to-back).
  - FULL & !out_ready -> FULL, with out_* held stable.
- Slot free: free = !out_valid | out_ready.
- Arbitration:
  - Combinational.
  - Winner = first k with in_valid[k]=1, scanning ptr, ptr+1, ... mod 4.
  - in_ready[k] = free & (k==winner) & in_valid[k].
  - At most one in_ready bit is high in any cycle.
  - On accept: out_data<=in_data[winner], out_sel<=winner, out_valid<=1, ptr<=(winner+1) mod 4.
  - ptr wraps 3->0.
- Latency and throughput:
  - Latency is 1 cycle from input accept to out_valid.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- No requests: ptr unchanged; the output slot drains normally.
- Fairness: with all four valid continuously, grants cycle 0,1,2,3,0,...
- Reset mid-operation: any pending output beat is discarded; no recovery of it is required.

Optional Feature:
- Macro: MUX_4TO1_RR_LOCK_EN.
- Defined:
  - Adds ports `in_last` input 4 and `out_last` output 1 (registered, reset 0).
  - After a grant on channel k whose beat has in_last[k]=0, arbitration is locked to k; other channels are ignored even if valid.
  - The lock releases after the beat with in_last[k]=1 is accepted.
  - ptr advances only on that last beat.
  - out_last is captured alongside out_data.
  - Reset clears the lock.
- Undefined:
  - Per-beat arbitration as above; no last ports exist.

Decomposition:
- Package mux_4to1_pkg:
  - N_CH=4, SEL_W=2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - Function next_ptr(sel_t) for the mod-4 increment.
- Sub-module rr_arb4:
  - Purely combinational: req[3:0], ptr -> grant one-hot [3:0] plus grant index.
  - Reusable for other 4-way arbiters.
- Top module holds ptr, the lock flop and the output register.

Test Plan:
- Reset then single beat: rst pulse; in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1.
  -> in_ready=4'b0100 in the same cycle.
  -> Next cycle out_valid=1, out_data=A5, out_sel=2.
- Round robin: all in_valid=1, data ch k = 8'h10+k, out_ready=1 for 8 cycles.
  -> out_sel sequence 0,1,2,3,0,1,2,3; out_data 10,11,12,13,...
- Backpressure: out_ready=0 with out_valid=1 holding 8'h33 for 5 cycles, ch1 valid.
  -> out_data stable at 33, in_ready=0.
  -> When out_ready rises, ch1 is accepted in that same cycle, giving a back-to-back beat.
- Pointer skip: after a grant to ch3 (ptr=0), only ch2 valid.
  -> ch2 granted.
  -> ptr becomes 3; a subsequent request from ch3 alone is granted next.
- Async reset mid-stream: rst asserted between edges while out_valid=1.
  -> out_valid, out_data and out_sel are 0 immediately, not at the next edge.
  -> After release, the first grant goes to ch0 when all channels are valid.
- LOCK_EN (macro defined): ch1 sends 3 beats with in_last=0,0,1 while ch0 is valid throughout.
  -> out_sel=1,1,1 with out_last=0,0,1; ch0 is then granted on the next beat.
